// File: rtl/csa_mult_seq.sv
// csa_mult_seq: iterative unsigned W x W multiplier.
// Adds one partial product per cycle into a redundant sum/carry pair through a
// 3:2 carry-save row, then resolves the pair with one carry-propagate add.
// Fixed latency: start accepted at edge N gives done=1 in the cycle after edge N+W+1.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   start  request, accepted only while busy=0
//   a, b   multiplicand / multiplier, captured on the accepting edge
//   busy   high while an operation is in flight
//   done   one-cycle pulse, p valid
//   p      2W-bit product, held until the next operation resolves
module csa_mult_seq #(
   parameter int unsigned W = 32
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   b,
   output logic           busy,
   output logic           done,
   output logic [2*W-1:0] p
);

   localparam int unsigned CntW = (W > 1) ? $clog2(W) : 1;
   localparam logic [CntW-1:0] LastCnt = CntW'(W - 1);

   typedef enum logic [1:0] {StIdle, StAccum, StResolve} state_e;

   state_e          state_q, state_d;
   logic [2*W-1:0]  a_q, a_d;
   logic [W-1:0]    b_q, b_d;
   logic [2*W-1:0]  s_q, s_d;
   logic [2*W-1:0]  c_q, c_d;
   logic [2*W-1:0]  p_q, p_d;
   logic [CntW-1:0] count_q, count_d;
   logic            done_q, done_d;
   logic [2*W-1:0]  pp;

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      s_d     = s_q;
      c_d     = c_q;
      p_d     = p_q;
      count_d = count_q;
      done_d  = 1'b0;
      pp      = '0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               a_d     = {{W{1'b0}}, a};
               b_d     = b;
               s_d     = '0;
               c_d     = '0;
               count_d = '0;
               state_d = StAccum;
            end
         end
         StAccum: begin
            pp = b_q[count_q] ? (a_q << count_q) : '0;
            // 3:2 compression; carry bit 2W-1 is dropped, lossless since the
            // product fits in 2W bits.
            s_d     = s_q ^ c_q ^ pp;
            c_d     = ((s_q & c_q) | (s_q & pp) | (c_q & pp)) << 1;
            count_d = count_q + CntW'(1);
            if (count_q == LastCnt) begin
               state_d = StResolve;
            end
         end
         StResolve: begin
            p_d     = s_q + c_q;
            done_d  = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StIdle;
         a_q     <= '0;
         b_q     <= '0;
         s_q     <= '0;
         c_q     <= '0;
         p_q     <= '0;
         count_q <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         s_q     <= s_d;
         c_q     <= c_d;
         p_q     <= p_d;
         count_q <= count_d;
         done_q  <= done_d;
      end
   end

   assign busy = (state_q != StIdle);
   assign done = done_q;
   assign p    = p_q;

endmodule

// File: tb/tb_csa_mult_seq.sv
// Self-checking bench for csa_mult_seq (W=32): table-driven products plus
// hand-written sequences for ignored start, mid-operation reset and back-to-back.
module tb_csa_mult_seq;

   localparam int unsigned W = 32;

   logic          clk;
   logic          rst_n;
   logic          start;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic          busy;
   logic          done;
   logic [63:0]   p;

   int n_checks = 0;
   int n_errors = 0;
   logic [63:0] held_p;

   typedef struct {
      logic [31:0] va;
      logic [31:0] vb;
      logic [63:0] exp_p;
      string       name;
   } vec_t;

   vec_t vecs[10];

   csa_mult_seq #(.W(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .p     (p)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout, required finish");
      $fatal(1);
   end

   task automatic check(input string name, input string what, input logic [63:0] act,
                        input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s %s: got 0x%0h, required 0x%0h", name, what, act, exp);
      end
   endtask

   // Starts an operation, checks busy/done/p and the S+C invariant at every edge.
   task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_v,
                         input logic [63:0] exp_p, input string name);
      logic [63:0] sc;
      logic [63:0] exp_sc;
      @(negedge clk);
      a = ta; b = tb_v; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; a = $urandom; b = $urandom;
      check(name, "busy@accept", 64'(busy), 64'd1);
      for (int i = 1; i <= int'(W); i++) begin
         @(posedge clk); #1;
         sc     = dut.s_q + dut.c_q;
         exp_sc = {32'd0, ta} * ({32'd0, tb_v} & ((64'd1 << i) - 64'd1));
         check(name, "s+c invariant", sc, exp_sc);
         check(name, "busy in flight", 64'(busy), 64'd1);
         check(name, "done in flight", 64'(done), 64'd0);
         check(name, "p held", p, held_p);
      end
      @(posedge clk); #1;
      check(name, "done", 64'(done), 64'd1);
      check(name, "busy in done cycle", 64'(busy), 64'd0);
      check(name, "product", p, exp_p);
      held_p = exp_p;
      @(posedge clk); #1;
      check(name, "done cleared", 64'(done), 64'd0);
      check(name, "p after done", p, exp_p);
   endtask

   initial begin
      int pulses;

      vecs[0] = '{32'd3,          32'd5,          64'h0000_0000_0000_000F, "3x5"};
      vecs[1] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'hFFFF_FFFE_0000_0001, "max"};
      vecs[2] = '{32'h1234_5678,  32'd0,          64'd0,                   "bzero"};
      vecs[3] = '{32'd0,          32'hDEAD_BEEF,  64'd0,                   "azero"};
      vecs[4] = '{32'd1,          32'd1,          64'd1,                   "1x1"};
      vecs[5] = '{32'hDEAD_BEEF,  32'd1,          64'h0000_0000_DEAD_BEEF, "ident"};
      vecs[6] = '{32'h8000_0000,  32'd2,          64'h0000_0001_0000_0000, "msb"};
      vecs[7] = '{32'hFFFF_FFFF,  32'd2,          64'h0000_0001_FFFF_FFFE, "shift"};
      vecs[8] = '{32'h0000_FFFF,  32'h0000_FFFF,  64'h0000_0000_FFFE_0001, "ffff"};
      vecs[9] = '{32'h8000_0000,  32'h8000_0000,  64'h4000_0000_0000_0000, "msb2"};

      // Reset, with start asserted to show reset overrides it.
      rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
      repeat (2) @(posedge clk);
      #1 start = 1'b1; a = 32'd9; b = 32'd9;
      @(posedge clk); #1;
      check("reset", "busy", 64'(busy), 64'd0);
      check("reset", "done", 64'(done), 64'd0);
      check("reset", "p", p, 64'd0);
      start = 1'b0; rst_n = 1'b1;
      held_p = 64'd0;
      @(posedge clk); #1;
      check("reset", "busy after release", 64'(busy), 64'd0);

      foreach (vecs[i]) run_op(vecs[i].va, vecs[i].vb, vecs[i].exp_p, vecs[i].name);

      // start during an operation is ignored.
      @(negedge clk);
      a = 32'd2; b = 32'd9; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      pulses = 0;
      for (int i = 1; i <= int'(W) + 4; i++) begin
         @(posedge clk); #1;
         if (done) pulses++;
         if (i == 9) begin
            start = 1'b1; a = 32'd7; b = 32'd7;
         end
         if (i == 10) start = 1'b0;
         if (i == int'(W) + 1) begin
            check("ignore", "done", 64'(done), 64'd1);
            check("ignore", "product", p, 64'h12);
         end
      end
      check("ignore", "done pulses", 64'(pulses), 64'd1);
      check("ignore", "busy after", 64'(busy), 64'd0);
      held_p = 64'h12;

      // Reset at edge N+20 of an operation aborts it.
      @(negedge clk);
      a = 32'd5; b = 32'd5; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (19) @(posedge clk);
      #1 rst_n = 1'b0;
      @(posedge clk); #1;
      check("abort", "busy", 64'(busy), 64'd0);
      check("abort", "done", 64'(done), 64'd0);
      check("abort", "p", p, 64'd0);
      rst_n = 1'b1;
      held_p = 64'd0;
      pulses = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (done) pulses++;
      end
      check("abort", "late done pulses", 64'(pulses), 64'd0);
      check("abort", "p stays", p, 64'd0);

      // Back-to-back: start held high, next operands presented in the done cycle.
      @(negedge clk);
      a = 32'h1_0000; b = 32'h1_0000; start = 1'b1;
      @(posedge clk); #1;
      repeat (W) @(posedge clk);
      @(posedge clk); #1;
      check("b2b", "first done", 64'(done), 64'd1);
      check("b2b", "first product", p, 64'h1_0000_0000);
      check("b2b", "busy in done cycle", 64'(busy), 64'd0);
      a = 32'd6; b = 32'd7;
      @(posedge clk); #1;
      check("b2b", "second accepted", 64'(busy), 64'd1);
      check("b2b", "done cleared", 64'(done), 64'd0);
      check("b2b", "p held", p, 64'h1_0000_0000);
      start = 1'b0;
      repeat (W) @(posedge clk);
      @(posedge clk); #1;
      check("b2b", "second done", 64'(done), 64'd1);
      check("b2b", "second product", p, 64'h2A);
      @(posedge clk); #1;
      check("b2b", "idle after", 64'(busy), 64'd0);
      check("b2b", "done cleared 2", 64'(done), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
